// File: rtl/fib_req_initiator_if.sv
// Strobe/busy request channel between the initiator and a Fibonacci calculator.
interface fib_req_initiator_if #(
    parameter int unsigned N_WIDTH      = 8,
    parameter int unsigned RESULT_WIDTH = 8
);
    logic [N_WIDTH-1:0]      fib_n;
    logic                    stb;
    logic                    busy;
    logic [RESULT_WIDTH-1:0] fib_number;

    modport master (
        output fib_n,
        output stb,
        input  busy,
        input  fib_number
    );

    modport slave (
        input  fib_n,
        input  stb,
        output busy,
        output fib_number
    );
endinterface

// File: rtl/fib_req_initiator.sv
// Self-test initiator: sweeps indices 0..count-1 through a Fibonacci calculator and checks each
// result against an internal iterative model (mod 2^RESULT_WIDTH), with a per-request watchdog.
module fib_req_initiator #(
    parameter int unsigned N_WIDTH      = 8,
    parameter int unsigned RESULT_WIDTH = 8,
    parameter int unsigned TIMEOUT      = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_WIDTH-1:0]      count,
    fib_req_initiator_if.master     req,
    output logic                    active,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [N_WIDTH-1:0]      fail_idx,
    output logic [RESULT_WIDTH-1:0] fail_expected,
    output logic [RESULT_WIDTH-1:0] fail_actual
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StSettle,
        StWait,
        StCheck,
        StDone
    } state_e;

    localparam logic [N_WIDTH-1:0]      NOne       = N_WIDTH'(1);
    localparam logic [RESULT_WIDTH-1:0] ROne       = RESULT_WIDTH'(1);
    localparam logic [15:0]             TimeoutCnt = 16'(TIMEOUT);

    state_e                  state_q;
    logic [N_WIDTH-1:0]      count_q;
    logic [N_WIDTH-1:0]      idx_q;
    logic [RESULT_WIDTH-1:0] cur_q;
    logic [RESULT_WIDTH-1:0] nxt_q;
    logic [RESULT_WIDTH-1:0] cap_q;
    logic [15:0]             wd_q;
    logic                    stb_q;
    logic [N_WIDTH-1:0]      fib_n_q;
    logic                    active_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    timeout_q;
    logic [N_WIDTH-1:0]      fail_idx_q;
    logic [RESULT_WIDTH-1:0] fail_expected_q;
    logic [RESULT_WIDTH-1:0] fail_actual_q;

    logic [15:0]             wd_inc;
    logic [N_WIDTH-1:0]      last_idx;
    logic [N_WIDTH-1:0]      idx_inc;

    assign wd_inc   = wd_q + 16'd1;
    assign last_idx = count_q - NOne;
    assign idx_inc  = idx_q + NOne;

    // Sweep sequencer: every output is registered and updated only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            count_q         <= '0;
            idx_q           <= '0;
            cur_q           <= '0;
            nxt_q           <= ROne;
            cap_q           <= '0;
            wd_q            <= '0;
            stb_q           <= 1'b0;
            fib_n_q         <= '0;
            active_q        <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            timeout_q       <= 1'b0;
            fail_idx_q      <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
        end else begin
            // Strobe is a single-cycle pulse; only the ISSUE entry raises it.
            stb_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        count_q         <= count;
                        idx_q           <= '0;
                        cur_q           <= '0;
                        nxt_q           <= ROne;
                        done_q          <= 1'b0;
                        pass_q          <= 1'b0;
                        timeout_q       <= 1'b0;
                        fail_idx_q      <= '0;
                        fail_expected_q <= '0;
                        fail_actual_q   <= '0;
                        if (count == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q  <= StIssue;
                            stb_q    <= 1'b1;
                            fib_n_q  <= '0;
                            active_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    wd_q    <= '0;
                    state_q <= StSettle;
                end
                // Busy is not trusted yet: the calculator needs a cycle to raise it.
                StSettle: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (!req.busy) begin
                        cap_q   <= req.fib_number;
                        state_q <= StCheck;
                    end else if (wd_inc == TimeoutCnt) begin
                        state_q         <= StDone;
                        active_q        <= 1'b0;
                        done_q          <= 1'b1;
                        pass_q          <= 1'b0;
                        timeout_q       <= 1'b1;
                        fail_idx_q      <= idx_q;
                        fail_expected_q <= cur_q;
                        fail_actual_q   <= '0;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                StCheck: begin
                    if (cap_q != cur_q) begin
                        state_q         <= StDone;
                        active_q        <= 1'b0;
                        done_q          <= 1'b1;
                        pass_q          <= 1'b0;
                        fail_idx_q      <= idx_q;
                        fail_expected_q <= cur_q;
                        fail_actual_q   <= cap_q;
                    end else if (idx_q == last_idx) begin
                        state_q  <= StDone;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        pass_q   <= 1'b1;
                    end else begin
                        idx_q    <= idx_inc;
                        cur_q    <= nxt_q;
                        nxt_q    <= cur_q + nxt_q;
                        state_q  <= StIssue;
                        stb_q    <= 1'b1;
                        fib_n_q  <= idx_inc;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req.stb       = stb_q;
    assign req.fib_n     = fib_n_q;
    assign active        = active_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign fail_idx      = fail_idx_q;
    assign fail_expected = fail_expected_q;
    assign fail_actual   = fail_actual_q;

endmodule
